// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized sig_in rising edges over a GATE_CYCLES window.
// Optional deglitch stage enabled by defining FREQ_METER_FILTER_EN.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_lvl_prev;
  logic              w_lvl;
  logic              w_edge;
  logic [GATE_W-1:0] r_gate;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_ovf;
  logic [CNT_W-1:0]  w_edge_cnt_nxt;
  logic              w_ovf_nxt;
  logic              w_cnt_max;
  logic              w_edge_inc;
  logic              w_gate_last;
  logic              r_busy;
  logic              r_valid;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  // Two-flop synchronizer for the asynchronous measured signal
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef FREQ_METER_FILTER_EN
  logic       r_filt;
  logic [1:0] r_stab;

  // Filtered level follows the synchronized level only after 3 stable cycles
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_stab <= 2'd0;
    end else if (r_sync2 == r_filt) begin
      r_stab <= 2'd0;
    end else if (r_stab == 2'd2) begin
      r_filt <= r_sync2;
      r_stab <= 2'd0;
    end else begin
      r_stab <= r_stab + 2'd1;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_sync2;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_prev <= 1'b0;
    end else begin
      r_lvl_prev <= w_lvl;
    end
  end

  assign w_edge         = w_lvl & ~r_lvl_prev;
  assign w_gate_last    = (r_gate == GATE_LAST);
  assign w_cnt_max      = &r_edge_cnt;
  assign w_edge_inc     = (r_state == MEASURE) && w_edge;
  // Saturating increment; an edge arriving at full scale flags overflow instead
  assign w_edge_cnt_nxt = (w_edge_inc && !w_cnt_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_ovf_nxt      = r_ovf | (w_edge_inc & w_cnt_max);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)       w_state_nxt = MEASURE;
      MEASURE: if (w_gate_last) w_state_nxt = DONE;
      DONE:    if (ack)         w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Window counters, result latch and registered status flags
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_gate     <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt == MEASURE);
      r_valid <= (w_state_nxt == DONE);
      if ((r_state == IDLE) && start) begin
        r_gate     <= '0;
        r_edge_cnt <= '0;
        r_ovf      <= 1'b0;
      end else if (r_state == MEASURE) begin
        r_gate     <= r_gate + GATE_W'(1);
        r_edge_cnt <= w_edge_cnt_nxt;
        r_ovf      <= w_ovf_nxt;
        if (w_gate_last) begin
          r_count    <= w_edge_cnt_nxt;
          r_overflow <= w_ovf_nxt;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign valid    = r_valid;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000, gate window length in clk_in cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 32, width of the edge counter and the count output.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port sig_in  input  1  measured signal, asynchronous to clk_in (e.g. capacitive sensor frequency output).
REQ-006 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-007 SHALL have port ack  input  1  consumer acknowledge of a valid result.
REQ-008 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-009 SHALL have port valid  output  1  result available on count/overflow.
REQ-010 SHALL have port count  output  CNT_W  number of sig_in rising edges in the last gate window.
REQ-011 SHALL have port overflow  output  1  edge counter saturated during the last window.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer, then detect rising edges (current 1, previous 0); this gives a 3-cycle detection latency.
REQ-013 SHALL implement states IDLE, MEASURE, DONE.
REQ-014 In IDLE: busy=0, valid=0; start=1 moves to MEASURE next cycle, clearing the gate counter and edge counter.
REQ-015 In MEASURE: busy=1; the gate counter increments every cycle; each detected edge increments the edge counter.
REQ-016 The gate window SHALL be exactly GATE_CYCLES MEASURE cycles; an edge detected on the last window cycle is counted, one detected on the following cycle is not.
REQ-017 Edges detected outside MEASURE, including any in the synchronizer pipeline at start, SHALL NOT be counted.
REQ-018 After the last window cycle, the FSM SHALL move to DONE, latch count and overflow, set valid=1 and busy=0.
REQ-019 The edge counter SHALL saturate at 2^CNT_W-1 without wrapping; any edge arriving at saturation sets overflow.
REQ-020 In DONE, valid, count and overflow SHALL stay stable until ack=1; on ack, the FSM returns to IDLE next cycle with valid=0.
REQ-021 start SHALL be ignored in MEASURE and DONE (not queued); if start and ack are both high in DONE, only ack takes effect.
REQ-022 count and overflow SHALL keep their last latched values in IDLE and MEASURE until the next DONE.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE and set busy, valid, count, overflow, synchronizer flops, and both counters to 0.
REQ-024 Reset during MEASURE or DONE SHALL discard the measurement; no valid is produced until a new start.

Configuration
REQ-025 The macro FREQ_METER_FILTER_EN, when defined, SHALL add a deglitch stage after the synchronizer: the filtered level changes only after the synchronized level has been stable for 3 consecutive cycles; edge detection then uses the filtered level, and detection latency becomes 6 cycles.
REQ-026 Without FREQ_METER_FILTER_EN, no filter logic SHALL exist, and edge detection uses the synchronized level directly.

Verification (sim parameters GATE_CYCLES=100, CNT_W=8 unless stated)
REQ-027 sig_in square wave, period 10 cycles (5 high/5 low), start pulse -> valid=1 after 100 MEASURE cycles, count=10, overflow=0.
REQ-028 sig_in held at 1 for the whole window -> count=0, overflow=0.
REQ-029 CNT_W=4, sig_in period 4 cycles (25 edges) -> count=15, overflow=1.
REQ-030 valid held for 20 cycles without ack while start pulses every 5 cycles -> count unchanged, no restart; ack -> valid=0 and busy=0 next cycle.
REQ-031 rst_n low at MEASURE cycle 50 -> all outputs 0 asynchronously; valid stays 0 for 200 cycles after release with no start.
REQ-032 Ten 1-cycle high pulses on sig_in in the window -> count=10 without FREQ_METER_FILTER_EN, count=0 with it.
